// File: rtl/drawcon_pkg.sv
// drawcon_pkg: shared types, wall bit indices, colours and sprite ROM addressing
// Exports rgb12_t, WALL_* bit indices, RGB_* default colours and sprite_addr().
package drawcon_pkg;
    typedef logic [11:0] rgb12_t;
    localparam int WALL_TOP   = 3;
    localparam int WALL_BOT   = 2;
    localparam int WALL_LEFT  = 1;
    localparam int WALL_RIGHT = 0;
    localparam rgb12_t RGB_WALL   = 12'hF00;
    localparam rgb12_t RGB_BG     = 12'h00F;
    localparam rgb12_t RGB_TRANSP = 12'h000;
    // Sprites are stored back to back, each as SPR_H rows of SPR_W texels.
    function automatic int unsigned sprite_addr(input int unsigned id, dx, dy, spr_w, spr_h);
        return id * spr_w * spr_h + dy * spr_w + dx;
    endfunction
endpackage

// File: rtl/tile_counter.sv
// tile_counter: one axis of the maze tile walk (offset inside tile + saturating tile index)
// Ports: clk, rst (sync, active high); clear zeroes both counts; advance steps pos,
// wrapping at limit-1 and bumping idx (saturating); pos/idx are the registered counts.
module tile_counter #(
    parameter int PW = 10,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [PW-1:0] limit,
    output logic [PW-1:0] pos,
    output logic [IW-1:0] idx
);
    logic wrap;
    assign wrap = pos == limit - 1'b1;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos <= '0;
            idx <= '0;
        end else if (advance) begin
            pos <= wrap ? '0 : pos + 1'b1;
            idx <= (wrap && idx != '1) ? idx + 1'b1 : idx;
        end
    end
endmodule

// File: rtl/drawcon_pipe.sv
// drawcon_pipe: 3-stage maze/sprite draw controller between VGA timing and RGB registers
// Inputs: pixel stream (pix_valid, line_start, frame_start, curr_x/y), level geometry
// (latched on frame_start), sprite enables/positions, walls_in and rom_data lookups.
// Outputs: maze_col/row and rom_addr (stage 1), draw_r/g/b + draw_valid (stage 3).
module drawcon_pipe
    import drawcon_pkg::*;
#(
    parameter int     N_SPR      = 4,
    parameter int     SPR_W      = 8,
    parameter int     SPR_H      = 8,
    parameter int     COORD_W    = 11,
    parameter int     MAZE_Y0    = 100,
    parameter rgb12_t TRANSP_KEY = RGB_TRANSP,
    parameter rgb12_t WALL_RGB   = RGB_WALL,
    parameter rgb12_t BG_RGB     = RGB_BG
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pix_valid,
    input  logic                                   line_start,
    input  logic                                   frame_start,
    input  logic [COORD_W-1:0]                     curr_x,
    input  logic [COORD_W-1:0]                     curr_y,
    input  logic [9:0]                             tile_w,
    input  logic [9:0]                             tile_h,
    input  logic [9:0]                             wall_margin,
    input  logic [4:0]                             num_cols,
    input  logic [4:0]                             num_rows,
    input  logic [N_SPR-1:0]                       spr_en,
    input  logic [N_SPR*COORD_W-1:0]               spr_x,
    input  logic [N_SPR*COORD_W-1:0]               spr_y,
    output logic [4:0]                             maze_col,
    output logic [4:0]                             maze_row,
    input  logic [3:0]                             walls_in,
    output logic [$clog2(N_SPR*SPR_W*SPR_H)-1:0]   rom_addr,
    input  logic [11:0]                            rom_data,
    output logic [3:0]                             draw_r,
    output logic [3:0]                             draw_g,
    output logic [3:0]                             draw_b,
    output logic                                   draw_valid
);
    localparam int AW = $clog2(N_SPR*SPR_W*SPR_H);
    localparam int DW = COORD_W + 1;
    logic [9:0] g_w, g_h, g_m, sw, sh, lim_w, lim_h, x_in, y_in;
    logic [4:0] g_c, g_r;
    logic fs_s, ls, ls_s, row_ok, in_maze, wall;
    logic v1, hit1, v2, hit2, paint2, hit_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] dx, dy;
    assign fs_s  = pix_valid & frame_start;
    assign ls    = line_start | frame_start;
    assign ls_s  = pix_valid & ls;
    assign sw    = tile_w == '0 ? 10'd1 : tile_w;
    assign sh    = tile_h == '0 ? 10'd1 : tile_h;
    // The frame_start pixel already counts with the geometry it is latching.
    assign lim_w = fs_s ? sw : g_w;
    assign lim_h = fs_s ? sh : g_h;
    always_ff @(posedge clk) begin
        if (rst) begin
            g_w <= 10'd1;
            g_h <= 10'd1;
            g_m <= '0;
            g_c <= '0;
            g_r <= '0;
        end else if (fs_s) begin
            g_w <= sw;
            g_h <= sh;
            g_m <= wall_margin;
            g_c <= num_cols;
            g_r <= num_rows;
        end
    end
    tile_counter #(.PW(10), .IW(5)) u_x (
        .clk(clk), .rst(rst), .clear(ls_s), .advance(pix_valid & ~ls),
        .limit(lim_w), .pos(x_in), .idx(maze_col)
    );
    tile_counter #(.PW(10), .IW(5)) u_y (
        .clk(clk), .rst(rst),
        .clear(ls_s && curr_y == COORD_W'(MAZE_Y0)),
        .advance(ls_s && curr_y > COORD_W'(MAZE_Y0)),
        .limit(lim_h), .pos(y_in), .idx(maze_row)
    );
    // Offsets use one extra bit so a pixel left of / above a sprite wraps to a large
    // value and misses; scanning downwards lets the lowest index win.
    always_comb begin
        hit_c  = 1'b0;
        addr_c = '0;
        dx     = '0;
        dy     = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            dx = {1'b0, curr_x} - {1'b0, spr_x[i*COORD_W +: COORD_W]};
            dy = {1'b0, curr_y} - {1'b0, spr_y[i*COORD_W +: COORD_W]};
            if (spr_en[i] && dx < DW'(SPR_W) && dy < DW'(SPR_H)) begin
                hit_c  = 1'b1;
                addr_c = AW'(sprite_addr(i, 32'(dx), 32'(dy), SPR_W, SPR_H));
            end
        end
    end
    assign in_maze = row_ok && maze_col < g_c && maze_row < g_r;
    // Far-edge tests are written as pos+margin >= size so a margin wider than the tile
    // cannot underflow.
    assign wall = (walls_in[WALL_TOP]   && y_in < g_m)
                | (walls_in[WALL_BOT]   && {1'b0, y_in} + {1'b0, g_m} >= {1'b0, g_h})
                | (walls_in[WALL_LEFT]  && x_in < g_m)
                | (walls_in[WALL_RIGHT] && {1'b0, x_in} + {1'b0, g_m} >= {1'b0, g_w});
    always_ff @(posedge clk) begin
        if (rst) begin
            row_ok     <= 1'b0;
            v1         <= 1'b0;
            hit1       <= 1'b0;
            rom_addr   <= '0;
            v2         <= 1'b0;
            hit2       <= 1'b0;
            paint2     <= 1'b0;
            draw_valid <= 1'b0;
            {draw_r, draw_g, draw_b} <= '0;
        end else begin
            if (ls_s && curr_y <= COORD_W'(MAZE_Y0))
                row_ok <= curr_y == COORD_W'(MAZE_Y0);
            v1 <= pix_valid;
            if (pix_valid) begin
                hit1     <= hit_c;
                rom_addr <= addr_c;
            end
            v2 <= v1;
            if (v1) begin
                hit2   <= hit1;
                paint2 <= in_maze & wall;
            end
            draw_valid <= v2;
            // rom_data is the ROM's own register, aligned with stage 2 here.
            if (v2)
                {draw_r, draw_g, draw_b} <= (hit2 && rom_data != TRANSP_KEY) ? rom_data
                                          : paint2 ? WALL_RGB : BG_RGB;
        end
    end
endmodule

// File: tb/tb_drawcon_pipe.sv
// tb_drawcon_pipe: scoreboard bench for drawcon_pipe with a behavioural pixel model
module tb_drawcon_pipe;
    logic        clk = 0, rst = 1;
    logic        pix_valid = 0, line_start = 0, frame_start = 0;
    logic [10:0] curr_x = 0, curr_y = 0;
    logic [9:0]  tile_w = 0, tile_h = 0, wall_margin = 0;
    logic [4:0]  num_cols = 0, num_rows = 0;
    logic [3:0]  en = 0, wall_pat = 0;
    logic [10:0] sx [4];
    logic [10:0] sy [4];
    logic [4:0]  maze_col, maze_row;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data, last;
    logic [11:0] rom [256];
    logic [3:0]  draw_r, draw_g, draw_b;
    logic        draw_valid;
    typedef struct { logic [11:0] rgb; int cyc; } exp_t;
    exp_t q[$];
    exp_t e;
    int cyc = 0, n_cmp = 0, n_err = 0;
    int g_w = 1, g_h = 1, g_m = 0, g_c = 0, g_r = 0, pi = 0, ln = 0;
    bit ok = 0;

    drawcon_pipe dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .line_start(line_start),
        .frame_start(frame_start), .curr_x(curr_x), .curr_y(curr_y),
        .tile_w(tile_w), .tile_h(tile_h), .wall_margin(wall_margin),
        .num_cols(num_cols), .num_rows(num_rows), .spr_en(en),
        .spr_x({sx[3], sx[2], sx[1], sx[0]}), .spr_y({sy[3], sy[2], sy[1], sy[0]}),
        .maze_col(maze_col), .maze_row(maze_row), .walls_in(wall_pat),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b), .draw_valid(draw_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) last = 12'h000;
        else if (draw_valid) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("rgb", {draw_r, draw_g, draw_b}, e.rgb);
                chk("latency", cyc - e.cyc, 3);
            end
            last = {draw_r, draw_g, draw_b};
        end else chk("hold", {draw_r, draw_g, draw_b}, last);
    end

    task automatic model_reset();
        g_w = 1; g_h = 1; g_m = 0; g_c = 0; g_r = 0; pi = 0; ok = 0;
    endtask

    // Model: tile position from pixel/line index by divide and modulo.
    task automatic pix(input int x, input int y, input bit ls, input bit fs);
        int xi, yi, col, row, cx, a;
        bit hit;
        logic [11:0] ex, t;
        cx = x & 2047;
        if (fs) begin
            g_w = tile_w == 0 ? 1 : int'(tile_w);
            g_h = tile_h == 0 ? 1 : int'(tile_h);
            g_m = int'(wall_margin); g_c = int'(num_cols); g_r = int'(num_rows);
        end
        if (ls || fs) begin
            pi = 0;
            if (y < 100) ok = 0;
            else if (y == 100) begin ok = 1; ln = 0; end
            else ln++;
        end else pi++;
        xi = pi % g_w; col = pi / g_w > 31 ? 31 : pi / g_w;
        yi = ln % g_h; row = ln / g_h > 31 ? 31 : ln / g_h;
        hit = 0; a = 0;
        for (int i = 0; i < 4; i++)
            if (!hit && en[i] && cx >= sx[i] && cx < sx[i] + 8 && y >= sy[i] && y < sy[i] + 8) begin
                hit = 1;
                a = i * 64 + (y - sy[i]) * 8 + (cx - sx[i]);
            end
        t = rom[a];
        if (hit && t != 12'h000) ex = t;
        else if (ok && col < g_c && row < g_r &&
                 ((wall_pat[3] && yi < g_m) || (wall_pat[2] && yi >= g_h - g_m) ||
                  (wall_pat[1] && xi < g_m) || (wall_pat[0] && xi >= g_w - g_m))) ex = 12'hF00;
        else ex = 12'h00F;
        pix_valid = 1; line_start = ls; frame_start = fs;
        curr_x = cx[10:0]; curr_y = 11'(y);
        if (!rst) q.push_back('{rgb: ex, cyc: cyc});
        @(posedge clk); #1;
        pix_valid = 0; line_start = 0; frame_start = 0;
        if (!rst) begin
            chk("maze_col", maze_col, col);
            if (ok) chk("maze_row", maze_row, row);
            if (hit) chk("rom_addr", rom_addr, a);
        end
    endtask

    task automatic line(input int y, input int x0, input int n, input bit fs = 0);
        for (int i = 0; i < n; i++) pix(x0 + i, y, i == 0, fs && i == 0);
    endtask

    task automatic cont(input int y, input int x0, input int n);
        for (int i = 0; i < n; i++) pix(x0 + i, y, 0, 0);
    endtask

    task automatic bubble(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic geo(input int tw, input int th, input int m, input int c, input int r);
        tile_w = 10'(tw); tile_h = 10'(th); wall_margin = 10'(m);
        num_cols = 5'(c); num_rows = 5'(r);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin sx[i] = 0; sy[i] = 0; end
        for (int i = 0; i < 256; i++)
            rom[i] = i < 64 ? 12'h880 : i < 128 ? 12'h0F0 : i < 192 ? 12'h0AB : 12'h0CD;
        bubble(3);
        chk("rst_r", draw_r, 0); chk("rst_g", draw_g, 0); chk("rst_b", draw_b, 0);
        chk("rst_valid", draw_valid, 0); chk("rst_col", maze_col, 0);
        chk("rst_row", maze_row, 0); chk("rst_addr", rom_addr, 0);
        rst = 0;
        model_reset();
        // Top walls: first four maze lines red, fifth background
        geo(32, 32, 4, 10, 10); wall_pat = 4'b1000;
        line(0, 0, 40, 1); bubble(2);
        for (int y = 99; y <= 105; y++) begin line(y, 0, 40); bubble(1); end
        bubble(4);
        // Right walls across the column wrap at x=32, with a bubble mid-line
        wall_pat = 4'b0001;
        line(0, 0, 8, 1); line(100, 0, 16); bubble(2); cont(100, 16, 24);
        bubble(4);
        // Sprite priority, transparency, enable and wrap-around
        sx[0] = 200; sy[0] = 150; sx[1] = 200; sy[1] = 150; en = 4'b0011;
        line(100, 192, 16); line(150, 192, 16); line(157, 196, 12); line(158, 196, 12);
        bubble(4);
        for (int i = 0; i < 64; i++) rom[i] = 12'h000;
        line(151, 192, 16);
        en = 4'b0010; line(152, 192, 16);
        sx[2] = 0; sy[2] = 150; en = 4'b0100; line(153, 2044, 8);
        sx[3] = 2044; sy[3] = 150; en = 4'b1000; line(154, 2044, 8);
        en = 4'b0000; line(155, 2044, 8);
        bubble(4);
        // Tile width change only takes effect at the next frame_start
        wall_pat = 4'b0010;
        line(0, 0, 8, 1); line(100, 0, 40);
        tile_w = 16; line(101, 0, 40);
        line(0, 0, 8, 1); line(100, 0, 40);
        tile_w = 0; line(0, 0, 4, 1); line(100, 0, 12);
        bubble(4);
        // Reset during a burst flushes the three pixels in flight
        pix(0, 100, 1, 0); pix(1, 100, 0, 0);
        rst = 1; pix(2, 100, 0, 0);
        q.delete(); rst = 0; model_reset();
        chk("flush_valid", draw_valid, 0);
        chk("flush_rgb", {draw_r, draw_g, draw_b}, 0);
        bubble(6);
        geo(32, 32, 4, 10, 10); wall_pat = 4'b1000;
        line(0, 0, 4, 1); line(100, 0, 8);
        bubble(8);
        chk("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/drawcon_pipe.md
Name: drawcon_pipe

Overview:
- Pipelined, parametrised successor to the maze/sprite draw controller. Sits between the VGA timing generator and the RGB output registers.
- Replaces per-pixel divide/modulo with incremental tile counters and supports N_SPR prioritised sprites, each backed by a synchronous sprite ROM with transparency.
- Latches level geometry at frame start so level changes never tear mid-frame. All outputs are registered, with a fixed 3-cycle latency.

Parameters:
- N_SPR, 4, number of sprite channels (1..8); index 0 has highest priority.
- SPR_W, 8, sprite width in pixels (power of 2).
- SPR_H, 8, sprite height in pixels (power of 2).
- COORD_W, 11, coordinate width.
- MAZE_Y0, 100, first screen line of the maze.
- TRANSP_KEY, 12'h000, ROM colour treated as transparent.
- WALL_RGB, 12'hF00, wall colour.
- BG_RGB, 12'h00F, background colour.

Ports:
- clk in 1: pixel clock.
- rst in 1: synchronous, active-high reset.
- pix_valid in 1: curr_x/curr_y is an active pixel this cycle.
- line_start in 1: qualifies the first active pixel of a line.
- frame_start in 1: qualifies the first active pixel of a frame; also implies line_start.
- curr_x in COORD_W: pixel x.
- curr_y in COORD_W: pixel y.
- tile_w in 10: level tile width; sampled on frame_start.
- tile_h in 10: level tile height; sampled on frame_start.
- wall_margin in 10: wall thickness; sampled on frame_start.
- num_cols in 5: maze columns; sampled on frame_start.
- num_rows in 5: maze rows; sampled on frame_start.
- spr_en in N_SPR: per-sprite enable.
- spr_x in N_SPR*COORD_W: sprite top-left x, packed with sprite i at bits [i*COORD_W +: COORD_W].
- spr_y in N_SPR*COORD_W: sprite top-left y, packed the same way.
- maze_col out 5: stage-1 tile column, drives the level wall lookup.
- maze_row out 5: stage-1 tile row.
- walls_in in 4: {top,bottom,left,right}; combinational from the level table on maze_row/maze_col; sampled in stage 2.
- rom_addr out clog2(N_SPR*SPR_W*SPR_H): sprite ROM address.
- rom_data in 12: ROM output, valid 1 cycle after rom_addr.
- draw_r out 4: red channel.
- draw_g out 4: green channel.
- draw_b out 4: blue channel.
- draw_valid out 1: RGB corresponds to the pixel presented 3 cycles earlier.

Behaviour:
- **Reset:**
  - draw_r/g/b=0, draw_valid=0, maze_row/col=0, rom_addr=0.
  - Latched geometry = {tile_w=1, tile_h=1, margin=0, cols=0, rows=0}, i.e. everything is background.
  - All pipeline valid bits cleared; rst mid-frame discards in-flight pixels, which produce no draw_valid.
- **Geometry latch:** on pix_valid & frame_start, sample tile_w/tile_h/wall_margin/num_cols/num_rows. A sampled value of 0 for tile_w or tile_h is stored as 1. The new geometry applies starting with that same pixel.
- **Stage 1 (registered on pix_valid):**
  - Column counters: on line_start, x_in_tile=0 and col=0. Otherwise x_in_tile increments; when x_in_tile==tile_w-1 it wraps to 0 and col increments, saturating at 31.
  - Row counters (update on line_start only):
    - curr_y<MAZE_Y0: row_ok=0.
    - curr_y==MAZE_Y0: row=0, y_in_tile=0, row_ok=1.
    - curr_y>MAZE_Y0: y_in_tile increments, wrapping at tile_h-1 and incrementing row (saturating at 31).
  - in_maze = row_ok & col<num_cols & row<num_rows.
  - Sprite hit: spr_en[i] & curr_x-spr_x[i] < SPR_W & curr_y-spr_y[i] < SPR_H, using unsigned COORD_W+1 subtraction so negative offsets miss. Lowest hit index wins.
  - rom_addr = id*SPR_W*SPR_H + dy*SPR_W + dx.
- **Stage 2:** sample rom_data and walls_in. Wall hit (evaluated with the latched geometry):
  - (walls[3] & y_in<margin) | (walls[2] & y_in>=tile_h-margin) | (walls[1] & x_in<margin) | (walls[0] & x_in>=tile_w-margin).
- **Stage 3 (colour mux):**
  - sprite hit & rom_data!=TRANSP_KEY → rom_data.
  - else in_maze & wall hit → WALL_RGB.
  - else → BG_RGB.
  - draw_valid = stage-2 valid.
- **Latency and bubbles:**
  - Latency is exactly 3 clk from the pix_valid sample to draw_valid.
  - A pix_valid=0 cycle inserts a bubble: counters hold and the outputs hold their last value with draw_valid=0.
- **Simultaneous events:** frame_start plus line_start with any geometry change is handled in the same cycle; the geometry latch has priority over counter use.

Decomposition:
- Package drawcon_pkg holds:
  - rgb12_t;
  - wall bit indices WALL_TOP=3, WALL_BOT=2, WALL_LEFT=1, WALL_RIGHT=0;
  - default colour constants;
  - function sprite_addr(id, dx, dy).
- One sub-module, tile_counter: a single axis counter (clear, advance, wrap at limit-1, saturating index), instantiated twice, once for x and once for y.

Test Plan:
- rst, then frame with tile_w=tile_h=32, margin=4, cols=rows=10, walls_in=4'b1000 → rows y=100..103 are F00, y=104 is 00F, and draw_valid rises 3 cycles after the first pix_valid.
- Column wrap: x=31→32 with walls_in=4'b0001 → x=28..31 are F00, x=32 is 00F, and maze_col steps 0→1 at x=32.
- Sprites 0 and 1 both at (200,150) with ROM texel values 12'h880 and 12'h0F0 → output 880. With sprite 0's texel = TRANSP_KEY → output 0F0.
- Sprite at x=0 with curr_x=2047 → no hit (wrap-around check); spr_en=0 → no hit.
- Change tile_w 32→16 mid-frame → no effect until the next frame_start, after which col=1 at x=16.
- Assert rst for 1 cycle during a pixel burst → no draw_valid for the 3 flushed pixels; outputs are 0 the cycle after reset.
